// File: rtl/alu_wide_seq.sv
// Multi-word sequencer that drives a 32-bit ALU one word per cycle (LSW first)
// and assembles a WORDS*32-bit result behind valid/ready handshakes.
module alu_wide_seq #(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [WORDS*32-1:0]    in_a,
    input  logic [WORDS*32-1:0]    in_b,
    input  logic                   in_cin,
    output logic [2:0]             alu_opcode,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic                   alu_cin,
    input  logic [31:0]            alu_result,
    input  logic                   alu_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*32-1:0]    out_result,
    output logic                   out_cout,
    output logic                   out_err
);

    localparam int WW = WORDS * 32;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_CUT = 3'b110;
    localparam logic [2:0] OP_ADD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [2:0]      op_q, op_d;
    logic [WW-1:0]   a_q, a_d;
    logic [WW-1:0]   b_q, b_d;
    logic [WW-1:0]   result_q, result_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        cout_d     = cout_q;
        err_d      = err_q;
        alu_opcode = 3'b000;
        alu_a      = 32'h0;
        alu_b      = 32'h0;
        alu_cin    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d     = in_op;
                    a_d      = in_a;
                    b_d      = in_b;
                    result_d = '0;
                    cout_d   = 1'b0;
                    idx_d    = '0;
                    carry_d  = (in_op == OP_ADD) ? in_cin : 1'b0;
                    if (in_op == OP_SHL || in_op == OP_SHR || in_op == OP_CUT) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                // carry_q is only ever nonzero for ADD, so it can feed cin unconditionally
                alu_opcode = op_q;
                alu_cin    = carry_q;
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IW'(w)) begin
                        alu_a                = a_q[w*32 +: 32];
                        alu_b                = b_q[w*32 +: 32];
                        result_d[w*32 +: 32] = alu_result;
                    end
                end
                if (op_q == OP_ADD) begin
                    carry_d = alu_cout;
                end
                if (idx_q == LAST_IDX) begin
                    cout_d  = (op_q == OP_ADD) ? alu_cout : 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_cout   = cout_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq with a behavioural 32-bit ALU on the alu_* ports.
module tb_alu_wide_seq;

    localparam int WORDS = 4;
    localparam int WW    = WORDS * 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [WW-1:0]   in_a;
    logic [WW-1:0]   in_b;
    logic            in_cin;
    logic [2:0]      alu_opcode;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic            alu_cin;
    logic [31:0]     alu_result;
    logic            alu_cout;
    logic            out_valid;
    logic            out_ready;
    logic [WW-1:0]   out_result;
    logic            out_cout;
    logic            out_err;

    int checks   = 0;
    int failures = 0;

    alu_wide_seq #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 32-bit unsigned ALU; only the wide-capable opcodes matter here
    always_comb begin
        alu_result = 32'h0;
        alu_cout   = 1'b0;
        case (alu_opcode)
            3'b000: alu_result = ~alu_a;
            3'b001: alu_result = alu_a & alu_b;
            3'b010: alu_result = alu_a | alu_b;
            3'b011: alu_result = alu_a ^ alu_b;
            3'b111: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'h0, alu_cin};
            default: alu_result = 32'h0;
        endcase
    end

    typedef struct {
        string         name;
        logic [2:0]    op;
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic          cin;
        logic [WW-1:0] exp_result;
        logic          exp_cout;
        logic          exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                               input logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one request, waits for out_valid; lat counts edges including the accept edge
    task automatic applyStimulus(input logic [2:0] op, input logic [WW-1:0] a,
                                 input logic [WW-1:0] b, input logic cin, output int lat);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic completeHandshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, "_in_ready_after"}, WW'(in_ready), WW'(1));
        checkOutput({name, "_out_valid_after"}, WW'(out_valid), WW'(0));
    endtask

    initial begin
        int lat;
        logic [WW-1:0] held;

        vecs[0]  = '{"add_carry_mid", 3'b111, {64'h0, 64'hFFFFFFFF_FFFFFFFF}, WW'(1), 1'b0,
                     {63'h0, 1'b1, 64'h0}, 1'b0, 1'b0};
        vecs[1]  = '{"add_ones_cin", 3'b111, {WW{1'b1}}, WW'(0), 1'b1, WW'(0), 1'b1, 1'b0};
        vecs[2]  = '{"add_7f_7f_cin", 3'b111, {1'b0, {(WW-1){1'b1}}}, {1'b0, {(WW-1){1'b1}}},
                     1'b1, {WW{1'b1}}, 1'b0, 1'b0};
        vecs[3]  = '{"add_msb_overflow", 3'b111, {1'b1, {(WW-1){1'b0}}},
                     {1'b1, {(WW-1){1'b0}}}, 1'b0, WW'(0), 1'b1, 1'b0};
        vecs[4]  = '{"xor_aa_55", 3'b011, {WORDS{32'hAAAAAAAA}}, {WORDS{32'h55555555}}, 1'b0,
                     {WW{1'b1}}, 1'b0, 1'b0};
        vecs[5]  = '{"not_pattern", 3'b000, {WORDS{32'h12345678}}, {WW{1'b1}}, 1'b1,
                     {WORDS{32'hEDCBA987}}, 1'b0, 1'b0};
        vecs[6]  = '{"and_mask", 3'b001, {WORDS{32'hF0F0F0F0}}, {WORDS{32'hFF00FF00}}, 1'b1,
                     {WORDS{32'hF000F000}}, 1'b0, 1'b0};
        vecs[7]  = '{"or_ends", 3'b010, WW'(1), {1'b1, {(WW-1){1'b0}}}, 1'b1,
                     {1'b1, {(WW-2){1'b0}}, 1'b1}, 1'b0, 1'b0};
        vecs[8]  = '{"shl_err", 3'b100, {WW{1'b1}}, WW'(3), 1'b1, WW'(0), 1'b0, 1'b1};
        vecs[9]  = '{"shr_err", 3'b101, {WW{1'b1}}, WW'(3), 1'b0, WW'(0), 1'b0, 1'b1};
        vecs[10] = '{"cut_err", 3'b110, {WORDS{32'hDEADBEEF}}, WW'(5), 1'b1, WW'(0), 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #22;
        checkOutput("reset_in_ready", WW'(in_ready), WW'(1));
        checkOutput("reset_out_valid", WW'(out_valid), WW'(0));
        checkOutput("reset_out_result", out_result, WW'(0));
        checkOutput("reset_cout_err", WW'({out_cout, out_err}), WW'(0));
        checkOutput("reset_alu", WW'({alu_opcode, alu_a, alu_b, alu_cin}), WW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            checkOutput({vecs[i].name, "_latency"}, WW'(lat),
                        vecs[i].exp_err ? WW'(1) : WW'(WORDS + 1));
            checkOutput({vecs[i].name, "_result"}, out_result, vecs[i].exp_result);
            checkOutput({vecs[i].name, "_cout"}, WW'(out_cout), WW'(vecs[i].exp_cout));
            checkOutput({vecs[i].name, "_err"}, WW'(out_err), WW'(vecs[i].exp_err));
            checkOutput({vecs[i].name, "_alu_idle_done"},
                        WW'({alu_opcode, alu_a, alu_b, alu_cin}), WW'(0));
            completeHandshake(vecs[i].name);
        end

        // Backpressure: result must hold and a new request must be refused while DONE
        applyStimulus(3'b111, WW'(32'hFFFFFFFF), WW'(32'h1), 1'b0, lat);
        held      = {{(WW-33){1'b0}}, 33'h1_00000000};
        in_op     = 3'b011;
        in_a      = {WW{1'b1}};
        in_b      = '0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", WW'(out_valid), WW'(1));
            checkOutput("bp_out_result", out_result, held);
            checkOutput("bp_in_ready", WW'(in_ready), WW'(0));
        end
        in_valid = 1'b0;
        completeHandshake("bp");
        @(posedge clk);
        #1;
        checkOutput("bp_not_accepted", WW'(in_ready), WW'(1));

        // Reset in the middle of an ADD, while idx==2
        in_op    = 3'b111;
        in_a     = {WW{1'b1}};
        in_b     = WW'(1);
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("mid_run_alu_a", WW'(alu_a), WW'(32'hFFFFFFFF));
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", WW'(out_valid), WW'(0));
        checkOutput("mid_rst_in_ready", WW'(in_ready), WW'(1));
        checkOutput("mid_rst_out_result", out_result, WW'(0));
        checkOutput("mid_rst_alu", WW'({alu_opcode, alu_a, alu_b, alu_cin}), WW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_out_valid", WW'(out_valid), WW'(0));
        checkOutput("post_rst_in_ready", WW'(in_ready), WW'(1));
        applyStimulus(3'b111, WW'(1), WW'(2), 1'b0, lat);
        checkOutput("post_rst_latency", WW'(lat), WW'(WORDS + 1));
        checkOutput("post_rst_result", out_result, WW'(3));
        checkOutput("post_rst_cout", WW'(out_cout), WW'(0));
        completeHandshake("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
